// File: rtl/uart_transmitter_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
// A byte moves on a rising clock edge where tx_valid and tx_ready are both high.
interface uart_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART serialiser: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// A one-byte holding slot lets the next frame follow the current stop bit with no idle gap.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave up,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             hold_full_q, hold_full_d;
    logic             tx_q, busy_q, done_q;
    logic [7:0]       shift_q, hold_q;
    logic             par_q;

    logic accept, bit_end, frame_end;
    logic load_hold, load_new, hold_wr, shift_adv;

    function automatic logic parity_of(input logic [7:0] b);
        return (^b) ^ ODD;
    endfunction

    assign up.tx_ready = ~hold_full_q;
    assign accept      = up.tx_valid & ~hold_full_q;
    assign bit_end     = (cnt_q == CNT_LAST);
    assign frame_end   = (state_q == S_STOP) && bit_end && (bit_q == LAST_STOP);

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        load_hold = 1'b0;
        load_new  = 1'b0;
        shift_adv = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (hold_full_q) begin
                    load_hold = 1'b1;
                    state_d   = S_START;
                end else if (accept) begin
                    load_new = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_adv = 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        // Chain straight into the next start bit when a byte is waiting.
                        bit_d = '0;
                        if (hold_full_q) begin
                            load_hold = 1'b1;
                            state_d   = S_START;
                        end else if (accept) begin
                            load_new = 1'b1;
                            state_d  = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        hold_wr     = accept & ~load_new;
        hold_full_d = hold_wr | (hold_full_q & ~load_hold);
    end

    // Outputs are registered from the current state, so the line lags the FSM by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            hold_full_q <= hold_full_d;
            busy_q      <= (state_q != S_IDLE);
            done_q      <= frame_end;
            case (state_q)
                S_START:  tx_q <= 1'b0;
                S_DATA:   tx_q <= shift_q[0];
                S_PARITY: tx_q <= par_q;
                default:  tx_q <= 1'b1;
            endcase
        end
    end

    // Parity is taken from the byte as it enters the shifter.
    always_ff @(posedge clk) begin
        if (load_hold) begin
            shift_q <= hold_q;
            par_q   <= parity_of(hold_q);
        end else if (load_new) begin
            shift_q <= up.tx_data;
            par_q   <= parity_of(up.tx_data);
        end else if (shift_adv) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end
        if (hold_wr) begin
            hold_q <= up.tx_data;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
